// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer types: state codes, opcodes,
// instruction classes, FunSel encodings and the idle control word.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH_L = 3'd0,
    S_FETCH_H = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    IC_BRA,
    IC_BNE,
    IC_BEQ,
    IC_LDI,
    IC_ALU,
    IC_HLT,
    IC_NOP
  } iclass_t;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_BEQ = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h03;
  localparam logic [5:0] OP_HLT = 6'h3F;
  // ALU class spans 0x10-0x1F: top two opcode bits are 01
  localparam logic [1:0] OP_ALU_HI = 2'b01;

  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_INC  = 3'b001;

  localparam logic [2:0] ARF_PC   = 3'b011;
  localparam logic [2:0] ARF_NONE = 3'b111;
  localparam logic [3:0] RF_NONE  = 4'b1111;
  localparam logic [1:0] MUXA_IMM = 2'b11;
  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXB_IMM = 2'b11;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] muxa_sel;
    logic [1:0] muxb_sel;
    logic       muxc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    rf_outa_sel:  3'b000,
    rf_outb_sel:  3'b000,
    rf_fun_sel:   3'b000,
    rf_reg_sel:   RF_NONE,
    rf_scr_sel:   4'b1111,
    alu_fun_sel:  5'b00000,
    alu_wf:       1'b0,
    arf_outc_sel: 2'b00,
    arf_outd_sel: 2'b00,
    arf_fun_sel:  3'b000,
    arf_reg_sel:  ARF_NONE,
    ir_lh:        1'b0,
    ir_write:     1'b0,
    mem_wr:       1'b0,
    mem_cs:       1'b1,
    muxa_sel:     2'b00,
    muxb_sel:     2'b00,
    muxc_sel:     1'b0
  };

  function automatic logic [3:0] onehot_low(input logic [1:0] rsel);
    return ~(4'b1000 >> rsel);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction decode: class, destination mask,
// ALU source selects and function code.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output logic [3:0]  rsel_mask,
  output logic [2:0]  sreg1,
  output logic [2:0]  sreg2,
  output logic [4:0]  alu_fun,
  output logic        illegal
);

  logic [5:0] op;
  logic [1:0] unused_imm_hi;

  assign op            = ir[15:10];
  assign rsel_mask     = onehot_low(ir[9:8]);
  assign sreg1         = ir[5:3];
  assign sreg2         = ir[2:0];
  assign alu_fun       = {1'b1, op[3:0]};
  assign unused_imm_hi = ir[7:6];
  assign illegal       = (iclass == IC_NOP);

  always_comb begin
    iclass = IC_NOP;
    unique case (1'b1)
      op == OP_BRA:          iclass = IC_BRA;
      op == OP_BNE:          iclass = IC_BNE;
      op == OP_BEQ:          iclass = IC_BEQ;
      op == OP_LDI:          iclass = IC_LDI;
      op[5:4] == OP_ALU_HI:  iclass = IC_ALU;
      op == OP_HLT:          iclass = IC_HLT;
      default:               iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Four-cycle fetch/decode/execute control FSM driving the
// datapath selects; outputs forced idle while Reset is low.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  T,
  output logic        Halted,
  output logic        Illegal
);

  state_t     state;
  iclass_t    iclass;
  logic [3:0] rsel_mask;
  logic [2:0] sreg1;
  logic [2:0] sreg2;
  logic [4:0] alu_fun;
  logic       dec_illegal;
  logic       zero;
  logic       take;
  logic [2:0] unused_flags;
  ctrl_t      c;

  opcode_decoder u_dec (
    .ir        (IROut),
    .iclass    (iclass),
    .rsel_mask (rsel_mask),
    .sreg1     (sreg1),
    .sreg2     (sreg2),
    .alu_fun   (alu_fun),
    .illegal   (dec_illegal)
  );

  assign zero         = FlagsOut[3];
  assign unused_flags = FlagsOut[2:0];
  assign take = (iclass == IC_BRA)
             || (iclass == IC_BNE && !zero)
             || (iclass == IC_BEQ && zero);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_FETCH_L;
    end else begin
      unique case (state)
        S_FETCH_L: state <= S_FETCH_H;
        S_FETCH_H: state <= S_DECODE;
        S_DECODE:  state <= (iclass == IC_HLT) ? S_HALT : S_EXEC;
        S_EXEC:    state <= S_FETCH_L;
        S_HALT:    state <= S_HALT;
        default:   state <= S_FETCH_L;
      endcase
    end
  end

  always_comb begin
    c = CTRL_IDLE;
    if (Reset) begin
      unique case (state)
        S_FETCH_L, S_FETCH_H: begin
          c.mem_cs       = 1'b0;
          c.mem_wr       = 1'b0;
          c.arf_outd_sel = 2'b00;
          c.ir_write     = 1'b1;
          c.ir_lh        = (state == S_FETCH_H);
          c.arf_reg_sel  = ARF_PC;
          c.arf_fun_sel  = FUN_INC;
        end
        S_EXEC: begin
          if (take) begin
            c.muxb_sel    = MUXB_IMM;
            c.arf_fun_sel = FUN_LOAD;
            c.arf_reg_sel = ARF_PC;
          end
          if (iclass == IC_LDI) begin
            c.muxa_sel   = MUXA_IMM;
            c.rf_fun_sel = FUN_LOAD;
            c.rf_reg_sel = rsel_mask;
          end
          if (iclass == IC_ALU) begin
            c.rf_outa_sel = sreg1;
            c.rf_outb_sel = sreg2;
            c.alu_fun_sel = alu_fun;
            c.alu_wf      = 1'b1;
            c.muxa_sel    = MUXA_ALU;
            c.rf_fun_sel  = FUN_LOAD;
            c.rf_reg_sel  = rsel_mask;
          end
        end
        default: c = CTRL_IDLE;
      endcase
    end
  end

  assign RF_OutASel  = c.rf_outa_sel;
  assign RF_OutBSel  = c.rf_outb_sel;
  assign RF_FunSel   = c.rf_fun_sel;
  assign RF_RegSel   = c.rf_reg_sel;
  assign RF_ScrSel   = c.rf_scr_sel;
  assign ALU_FunSel  = c.alu_fun_sel;
  assign ALU_WF      = c.alu_wf;
  assign ARF_OutCSel = c.arf_outc_sel;
  assign ARF_OutDSel = c.arf_outd_sel;
  assign ARF_FunSel  = c.arf_fun_sel;
  assign ARF_RegSel  = c.arf_reg_sel;
  assign IR_LH       = c.ir_lh;
  assign IR_Write    = c.ir_write;
  assign Mem_WR      = c.mem_wr;
  assign Mem_CS      = c.mem_cs;
  assign MuxASel     = c.muxa_sel;
  assign MuxBSel     = c.muxb_sel;
  assign MuxCSel     = c.muxc_sel;

  assign T       = state;
  assign Halted  = Reset && (state == S_HALT);
  assign Illegal = Reset && (state == S_EXEC) && dec_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of EXEC-cycle
// vectors plus reset, fetch and halt sequences.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  T;
  logic        Halted, Illegal;

  int errors = 0;
  int checks = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .T(T), .Halted(Halted), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flags;
    logic [3:0]  rf_reg;
    logic [2:0]  rf_fun;
    logic [1:0]  muxa;
    logic [2:0]  outa;
    logic [2:0]  outb;
    logic [4:0]  alu_fun;
    logic        alu_wf;
    logic [2:0]  arf_reg;
    logic [2:0]  arf_fun;
    logic [1:0]  muxb;
    logic        illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    IROut    = 16'hFC00;
    FlagsOut = v.flags;
    chk({s, "_fl_T"}, T, 0);
    chk({s, "_fl_irw"}, IR_Write, 1);
    chk({s, "_fl_lh"}, IR_LH, 0);
    chk({s, "_fl_arffun"}, ARF_FunSel, 3'b001);
    chk({s, "_fl_cs"}, Mem_CS, 0);
    tick();
    chk({s, "_fh_T"}, T, 1);
    chk({s, "_fh_lh"}, IR_LH, 1);
    chk({s, "_fh_irw"}, IR_Write, 1);
    chk({s, "_fh_arffun"}, ARF_FunSel, 3'b001);
    chk({s, "_fh_arfreg"}, ARF_RegSel, 3'b011);
    IROut = v.ir;
    tick();
    chk({s, "_dec_T"}, T, 2);
    chk({s, "_dec_irw"}, IR_Write, 0);
    chk({s, "_dec_rfreg"}, RF_RegSel, 4'hF);
    chk({s, "_dec_cs"}, Mem_CS, 1);
    tick();
    chk({s, "_ex_T"}, T, 3);
    chk({s, "_ex_rfreg"}, RF_RegSel, v.rf_reg);
    chk({s, "_ex_rffun"}, RF_FunSel, v.rf_fun);
    chk({s, "_ex_muxa"}, MuxASel, v.muxa);
    chk({s, "_ex_outa"}, RF_OutASel, v.outa);
    chk({s, "_ex_outb"}, RF_OutBSel, v.outb);
    chk({s, "_ex_alufun"}, ALU_FunSel, v.alu_fun);
    chk({s, "_ex_aluwf"}, ALU_WF, v.alu_wf);
    chk({s, "_ex_arfreg"}, ARF_RegSel, v.arf_reg);
    chk({s, "_ex_arffun"}, ARF_FunSel, v.arf_fun);
    chk({s, "_ex_muxb"}, MuxBSel, v.muxb);
    chk({s, "_ex_ill"}, Illegal, v.illegal);
    chk({s, "_ex_cs"}, Mem_CS, 1);
    chk({s, "_ex_irw"}, IR_Write, 0);
    tick();
    chk({s, "_next_T"}, T, 0);
    chk({s, "_next_ill"}, Illegal, 0);
  endtask

  initial begin
    // ir, flags, rf_reg, rf_fun, muxa, outa, outb, alu, wf,
    // arf_reg, arf_fun, muxb, illegal
    vecs[0]  = '{16'h0042, 4'h0, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b011, 3'b010, 2'b11, 1'b0};
    vecs[1]  = '{16'h0442, 4'h0, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b011, 3'b010, 2'b11, 1'b0};
    vecs[2]  = '{16'h0442, 4'h8, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[3]  = '{16'h0842, 4'h8, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b011, 3'b010, 2'b11, 1'b0};
    vecs[4]  = '{16'h0842, 4'h7, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[5]  = '{16'h0C55, 4'h0, 4'h7, 3'b010, 2'b11, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[6]  = '{16'h0F55, 4'h0, 4'hE, 3'b010, 2'b11, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[7]  = '{16'h4253, 4'h0, 4'hD, 3'b010, 2'b00, 3'd2, 3'd3,
                 5'b10000, 1'b1, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[8]  = '{16'h7F7F, 4'hF, 4'hE, 3'b010, 2'b00, 3'd7, 3'd7,
                 5'b11111, 1'b1, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[9]  = '{16'h4519, 4'h0, 4'hB, 3'b010, 2'b00, 3'd3, 3'd1,
                 5'b10001, 1'b1, 3'b111, 3'b000, 2'b00, 1'b0};
    vecs[10] = '{16'h2000, 4'h0, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b1};
    vecs[11] = '{16'h8100, 4'h8, 4'hF, 3'd0, 2'd0, 3'd0, 3'd0,
                 5'h00, 1'b0, 3'b111, 3'b000, 2'b00, 1'b1};

    Reset    = 1'b0;
    IROut    = 16'h4253;
    FlagsOut = 4'h0;
    tick();
    tick();
    chk("rst_T", T, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_ill", Illegal, 0);
    chk("rst_rfreg", RF_RegSel, 4'hF);
    chk("rst_scr", RF_ScrSel, 4'hF);
    chk("rst_arfreg", ARF_RegSel, 3'b111);
    chk("rst_cs", Mem_CS, 1);
    chk("rst_irw", IR_Write, 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("rel_T", T, 0);
    chk("rel_irw", IR_Write, 1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    IROut = 16'hFC00;
    tick();
    tick();
    tick();
    chk("hlt_T", T, 7);
    chk("hlt_halted", Halted, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("hlt_hold_T", T, 7);
    chk("hlt_hold_halted", Halted, 1);
    chk("hlt_hold_cs", Mem_CS, 1);
    chk("hlt_hold_irw", IR_Write, 0);
    chk("hlt_hold_arfreg", ARF_RegSel, 3'b111);

    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("hltrst_T", T, 0);
    chk("hltrst_halted", Halted, 0);
    @(negedge Clock);
    Reset = 1'b1;

    IROut = 16'h4253;
    tick();
    tick();
    tick();
    chk("mid_T", T, 3);
    chk("mid_wf", ALU_WF, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_T", T, 0);
    chk("mid_rst_rfreg", RF_RegSel, 4'hF);
    chk("mid_rst_cs", Mem_CS, 1);
    chk("mid_rst_wf", ALU_WF, 0);
    tick();
    chk("mid_hold_T", T, 0);
    chk("mid_hold_irw", IR_Write, 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("mid_rel_T", T, 0);
    chk("mid_rel_irw", IR_Write, 1);
    chk("mid_rel_lh", IR_LH, 0);
    tick();
    chk("mid_rel_next_T", T, 1);
    chk("mid_rel_next_lh", IR_LH, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port IROut  input  16  instruction register contents from the datapath.
REQ-004 SHALL have port FlagsOut  input  4  ALU flags {Z,C,N,O}, Z = bit 3.
REQ-005 SHALL have outputs RF_OutASel, RF_OutBSel, RF_FunSel (3 each), RF_RegSel, RF_ScrSel (4 each), ALU_FunSel (5), ALU_WF (1), ARF_OutCSel, ARF_OutDSel (2 each), ARF_FunSel, ARF_RegSel (3 each), IR_LH, IR_Write, Mem_WR, Mem_CS (1 each), MuxASel, MuxBSel (2 each), MuxCSel (1), all driving the datapath of the same names.
REQ-006 SHALL have outputs T  3  current state code; Halted  1  high in HALT; Illegal  1  one-cycle pulse on undefined opcode.

Function
REQ-007 SHALL implement states FETCH_L(0), FETCH_H(1), DECODE(2), EXEC(3), HALT(7); T = state code.
REQ-008 SHALL transition FETCH_L->FETCH_H->DECODE->EXEC->FETCH_L unconditionally, except HLT: DECODE->HALT, HALT held until Reset.
REQ-009 SHALL drive idle values in every state unless overridden: RF_RegSel=1111, RF_ScrSel=1111, ARF_RegSel=111, IR_Write=0, Mem_CS=1, Mem_WR=0, ALU_WF=0, all selects/FunSels 0.
REQ-010 SHALL, in FETCH_L: Mem_CS=0, Mem_WR=0, ARF_OutDSel=00 (PC), IR_Write=1, IR_LH=0, ARF_RegSel=011, ARF_FunSel=001 (PC+1).
REQ-011 SHALL, in FETCH_H: identical to FETCH_L but IR_LH=1.
REQ-012 SHALL decode opcode = IROut[15:10], RSEL = IROut[9:8], IMM = IROut[7:0], SREG1 = IROut[5:3], SREG2 = IROut[2:0]; DECODE drives idle values.
REQ-013 SHALL, in EXEC, for BRA (0x00): MuxBSel=11, ARF_FunSel=010, ARF_RegSel=011 (PC <- IMM).
REQ-014 SHALL, for BNE (0x01) / BEQ (0x02): perform BRA actions only when Z=0 / Z=1, else idle.
REQ-015 SHALL, for LDI (0x03): MuxASel=11, RF_FunSel=010, RF_RegSel with bit (3-RSEL) low (R1=0111 .. R4=1110).
REQ-016 SHALL, for ALU class (0x10-0x1F): RF_OutASel=SREG1, RF_OutBSel=SREG2, ALU_FunSel={1,opcode[3:0]}, ALU_WF=1, MuxASel=00, RF_FunSel=010, RF_RegSel per RSEL.
REQ-017 SHALL, for HLT (0x3F): enter HALT; HALT drives idle values, Halted=1.
REQ-018 SHALL treat any other opcode as NOP: EXEC idle, Illegal=1 for the EXEC cycle only.
REQ-019 SHALL produce every output combinationally from state, IROut and FlagsOut sampled in the same cycle (Moore on state, Mealy on flags only for BNE/BEQ).
REQ-020 SHALL force all outputs to idle values whenever Reset is low, independent of state.
REQ-021 SHALL complete every non-halt instruction in exactly 4 cycles; PC incremented twice per fetch, wraps 0xFFFF->0x0000 inside the ARF.

Reset
REQ-022 SHALL, on Reset low, set state to FETCH_L immediately (T=0, Halted=0, Illegal=0).
REQ-023 SHALL, on Reset deassertion, begin FETCH_L at the next rising Clock; reset mid-instruction abandons it with no further writes.

Structure
REQ-024 SHALL place state codes, opcode constants, idle-value constants and FunSel encodings (LOAD=010, INC=001) in shared package cpu_ctrl_pkg.
REQ-025 SHALL contain one sub-module, opcode_decoder (combinational: IROut -> instruction class, RSEL one-hot-low, illegal flag).

Verification
REQ-026 SHALL verify reset: Reset=0 mid-EXEC of ALU op -> T=0, RF_RegSel=1111, Mem_CS=1 same cycle; release -> FETCH_L next edge.
REQ-027 SHALL verify fetch: IROut ignored, two cycles -> IR_Write=1 with IR_LH=0 then 1, ARF_FunSel=001 both cycles.
REQ-028 SHALL verify branch: IROut=0x0442 (BNE, IMM=0x42), Z=0 -> EXEC MuxBSel=11, ARF_RegSel=011; Z=1 -> ARF_RegSel=111.
REQ-029 SHALL verify ALU op: IROut=0x4253 (opcode 0x10, RSEL=2, SREG1=2, SREG2=3) -> ALU_FunSel=10000, RF_OutASel=010, RF_OutBSel=011, RF_RegSel=1101, ALU_WF=1.
REQ-030 SHALL verify halt/illegal: IROut=0xFC00 -> T=7, Halted=1 indefinitely; IROut=0x2000 -> Illegal=1 for one cycle, then FETCH_L.
